// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Responder FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Bytes per memory word (data path is fixed at 32 bits)
  localparam int DMEM_WORD_BYTES = 4;

  // Error causes reported on an access
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_sram_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_sram_array
//  Description : Single-port synchronous word RAM with per-byte write enables.
//                Read data is registered and appears one cycle after en; it
//                holds its value while en is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [DMEM_WORD_BYTES-1:0]     wstrb,
  input  logic [IDX_W-1:0]               idx,
  input  logic [8*DMEM_WORD_BYTES-1:0]   wdata,
  output logic [8*DMEM_WORD_BYTES-1:0]   rdata
);

  logic [8*DMEM_WORD_BYTES-1:0] r_mem [DEPTH];

  // Byte-masked write, or registered read of the addressed word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
          if (wstrb[b]) begin
            r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= r_mem[idx];
      end
    end
  end

endmodule : dmem_sram_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Responder end of the data-memory interface. Accepts one
//                load/store at a time, waits a programmable number of cycles,
//                performs the SRAM access and returns a response. Misaligned
//                or out-of-range accesses are flagged and never touch memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  input  logic [DMEM_WORD_BYTES-1:0] req_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int                 c_idx_w    = $clog2(MEM_DEPTH);
  localparam int                 c_cnt_w    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  // The counter runs WAIT_CYCLES down to 0; the cycle at 0 is the SRAM
  // access cycle, so the response lands 1+WAIT_CYCLES edges after acceptance.
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES);

  dmem_state_t                r_state;
  logic [c_cnt_w-1:0]         r_cnt;
  logic                       r_write;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [DMEM_WORD_BYTES-1:0] r_wstrb;
  logic                       r_rsp_load;

  logic [ADDR_WIDTH-3:0]      w_word;
  logic [c_idx_w-1:0]         w_idx;
  logic [1:0]                 w_err_cause;
  logic                       w_err;
  logic                       w_mem_en;
  logic                       w_mem_we;
  logic [DATA_WIDTH-1:0]      w_mem_rdata;
  logic                       w_req_hs;
  logic                       w_rsp_hs;

  // Address decode and error classification from the latched request
  always_comb begin
    w_word      = r_addr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
    w_idx       = w_word[c_idx_w-1:0];
    w_err_cause = ERR_NONE;
    if (r_addr[1:0] != 2'b00) begin
      w_err_cause = ERR_MISALIGN;
    end else if ((r_addr < BASE_ADDR) || (w_word >= (ADDR_WIDTH-2)'(MEM_DEPTH))) begin
      w_err_cause = ERR_RANGE;
    end
    w_err = (w_err_cause != ERR_NONE);
  end

  // Handshakes and the SRAM access strobe (final WAIT cycle, error-free only)
  always_comb begin
    w_req_hs = req_valid && req_ready;
    w_rsp_hs = rsp_valid && rsp_ready;
    w_mem_en = (r_state == ST_WAIT) && (r_cnt == '0) && !w_err;
    w_mem_we = w_mem_en && r_write;
  end

  dmem_sram_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (c_idx_w)
  ) u_sram (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (w_mem_we),
    .wstrb (r_wstrb),
    .idx   (w_idx),
    .wdata (r_wdata),
    .rdata (w_mem_rdata)
  );

  // The SRAM output register holds the loaded word for the whole RESP phase
  assign rsp_rdata = r_rsp_load ? w_mem_rdata : '0;

  // Request/response FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rsp_load <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (w_req_hs) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_cnt     <= c_cnt_load;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= w_err;
            r_rsp_load <= !r_write && !w_err;
            r_state    <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            r_rsp_load <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Scoreboard bench for dmem_responder, three instances with
//                WAIT_CYCLES of 0, 1 and 4 exercised one after another.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int NDUT = 3;
  localparam int c_wait [NDUT] = '{0, 1, 4};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;

  logic        req_valid [NDUT];
  logic        req_write [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_wstrb [NDUT];
  logic        rsp_ready [NDUT];
  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
  logic        busy      [NDUT];

  exp_t        sbq [$];
  logic [31:0] mdl [int];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_cyc  = 0;

  always #5 clk = ~clk;

  // Edge counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      dmem_responder #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (1024),
        .BASE_ADDR   (32'h0),
        .WAIT_CYCLES (c_wait[g])
      ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .req_write (req_write[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .req_wstrb (req_wstrb[g]),
        .rsp_valid (rsp_valid[g]),
        .rsp_ready (rsp_ready[g]),
        .rsp_rdata (rsp_rdata[g]),
        .rsp_err   (rsp_err[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive a request (called at a negedge), wait for acceptance, push expectation
  task automatic t_send(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st, output int acc);
    exp_t        e;
    logic [31:0] w;
    int          k;
    int          i = 0;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = st;
    while (!req_ready[d] && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (!req_ready[d]) begin
      chk($sformatf("d%0d accept_timeout", d), 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      acc = -1;
      return;
    end
    acc   = cyc + 1;
    e.acc = acc;
    e.err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
    e.rdata = 32'h0;
    if (!e.err) begin
      k = d * 4096 + int'(a >> 2);
      w = mdl.exists(k) ? mdl[k] : 32'h0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        mdl[k] = w;
      end else begin
        e.rdata = w;
      end
    end
    sbq.push_back(e);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Wait for the response, hold rsp_ready low for 'hold' cycles, then complete
  task automatic t_recv(input int d, input int hold);
    exp_t e;
    int   i = 0;
    while (!rsp_valid[d] && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (!rsp_valid[d]) begin
      chk($sformatf("d%0d rsp_timeout", d), 32'd0, 32'd1);
      return;
    end
    if (sbq.size() == 0) begin
      chk($sformatf("d%0d sb_empty", d), 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("d%0d latency", d), 32'(cyc - e.acc), 32'(1 + c_wait[d]));
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("d%0d hold_valid", d), 32'(rsp_valid[d]), 32'd1);
      chk($sformatf("d%0d hold_rdata", d), rsp_rdata[d], e.rdata);
      chk($sformatf("d%0d hold_req_ready", d), 32'(req_ready[d]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[d] = 1'b1;
    chk($sformatf("d%0d rdata", d), rsp_rdata[d], e.rdata);
    chk($sformatf("d%0d err", d), 32'(rsp_err[d]), 32'(e.err));
    chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'd1);
    @(negedge clk);
    hs_cyc = cyc;
    rsp_ready[d] = 1'b0;
    chk($sformatf("d%0d post_valid", d), 32'(rsp_valid[d]), 32'd0);
    chk($sformatf("d%0d post_rdata", d), rsp_rdata[d], 32'h0);
    chk($sformatf("d%0d post_err", d), 32'(rsp_err[d]), 32'd0);
    chk($sformatf("d%0d post_req_ready", d), 32'(req_ready[d]), 32'd1);
  endtask

  task automatic t_txn(input int d, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    int acc;
    t_send(d, wr, a, wd, st, acc);
    if (acc >= 0) t_recv(d, 0);
  endtask

  // Start a store to 0x20 and reset while it is still waiting
  task automatic t_abort(input int d);
    int i = 0;
    req_valid[d] = 1'b1;
    req_write[d] = 1'b1;
    req_addr[d]  = 32'h20;
    req_wdata[d] = 32'hCAFEF00D;
    req_wstrb[d] = 4'hF;
    while (!req_ready[d] && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("d%0d abort_accept", d), 32'(req_ready[d]), 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    chk($sformatf("d%0d abort_busy", d), 32'(busy[d]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk($sformatf("d%0d rst_req_ready", d), 32'(req_ready[d]), 32'd0);
    chk($sformatf("d%0d rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
    chk($sformatf("d%0d rst_busy", d), 32'(busy[d]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk($sformatf("d%0d rst_rel_ready", d), 32'(req_ready[d]), 32'd1);
  endtask

  task automatic run_suite(input int d);
    int acc_a;
    int acc_b;
    // word 0 seeded so that an aliased out-of-range store would be visible
    t_txn(d, 1'b1, 32'h0,   32'h0BADF00D, 4'hF);
    t_txn(d, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF);
    t_txn(d, 1'b0, 32'h10,  32'h0,        4'h0);
    t_txn(d, 1'b1, 32'h10,  32'h000000AA, 4'b0001);
    t_txn(d, 1'b0, 32'h10,  32'h0,        4'h0);
    t_txn(d, 1'b1, 32'h10,  32'h12345678, 4'b0000);
    t_txn(d, 1'b0, 32'h10,  32'h0,        4'h0);
    t_txn(d, 1'b0, 32'h12,  32'h0,        4'h0);
    t_txn(d, 1'b0, 32'h1000, 32'h0,       4'h0);
    t_txn(d, 1'b1, 32'h1000, 32'h55,      4'hF);
    t_txn(d, 1'b0, 32'h0,   32'h0,        4'h0);
    t_txn(d, 1'b0, 32'h10,  32'h0,        4'h0);
    t_txn(d, 1'b1, 32'hFFC, 32'h76543210, 4'hF);
    t_txn(d, 1'b0, 32'hFFC, 32'h0,        4'h0);
    // stalled response with a second request queued behind it
    t_send(d, 1'b0, 32'h10, 32'h0, 4'h0, acc_a);
    req_valid[d] = 1'b1;
    req_write[d] = 1'b0;
    req_addr[d]  = 32'h0;
    if (acc_a >= 0) t_recv(d, 5);
    t_send(d, 1'b0, 32'h0, 32'h0, 4'h0, acc_b);
    chk($sformatf("d%0d queued_accept", d), 32'(acc_b), 32'(hs_cyc + 1));
    if (acc_b >= 0) t_recv(d, 0);
    // reset during the wait phase of a store
    t_txn(d, 1'b1, 32'h20, 32'h11223344, 4'hF);
    t_abort(d);
    t_txn(d, 1'b0, 32'h20, 32'h0, 4'h0);
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b1;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'h0;
      req_wstrb[d] = 4'h0;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("d%0d reset_req_ready", d), 32'(req_ready[d]), 32'd0);
        chk($sformatf("d%0d reset_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
        chk($sformatf("d%0d reset_rdata", d), rsp_rdata[d], 32'h0);
        chk($sformatf("d%0d reset_busy", d), 32'(busy[d]), 32'd0);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d release_ready", d), 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
    end
    for (int d = 0; d < NDUT; d++) run_suite(d);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule : tb_dmem_responder
`default_nettype wire
